// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared types and constants for the UART command parser.
//   state_e            : parser FSM states (3-bit encoding)
//   SYNC_BYTE_DEFAULT  : default frame start marker
//   ADDR_*             : PID register bank addresses
//   frame_chksum()     : 8-bit wrapping sum of ADDR + DATA_H + DATA_L
// The checksum stage is only used when UART_CMD_CHKSUM_EN is defined.
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_ADDR = 3'd1,
    S_DH   = 3'd2,
    S_DL   = 3'd3,
    S_CHK  = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [7:0] ADDR_KP       = 8'h01;
  localparam logic [7:0] ADDR_KI       = 8'h02;
  localparam logic [7:0] ADDR_KD       = 8'h03;
  localparam logic [7:0] ADDR_SETPOINT = 8'h04;

  function automatic logic [7:0] frame_chksum(input logic [7:0]  addr,
                                               input logic [15:0] data);
    return addr + data[15:8] + data[7:0];
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// -----------------------------------------------------------------------------
// uart_cmd_timeout
// 16-bit idle counter used to abandon a stalled frame.
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   i_clr    : clear counter to 0 (takes priority over i_en)
//   i_en     : count one idle clock
//   o_expire : 1-cycle pulse when the counter sits at LIMIT-1 while enabled
// The counter returns to 0 on the expiry edge so the block can be reused
// without an external clear. LIMIT must lie in 2..65535.
// -----------------------------------------------------------------------------
module uart_cmd_timeout #(
  parameter int unsigned LIMIT = 8680
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] cnt_q, cnt_d;

  assign o_expire = i_en && !i_clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr || o_expire) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
// Assembles fixed-length command frames from the UART receiver byte stream and
// issues one-cycle register-write strobes to the PID register bank.
//   Frame: SYNC, ADDR, DATA_H, DATA_L [, CHK]
//   Optional feature macro: UART_CMD_CHKSUM_EN (adds the CHK byte and check).
// Ports:
//   i_Clock, i_Rst_n (async, active-low)
//   i_RX_DV, i_RX_Byte : receiver strobe and byte
//   o_Wr_DV            : 1-cycle write strobe per good frame
//   o_Wr_Addr/o_Wr_Data: committed address/data, held between commits
//   o_Err_Cnt          : saturating count of dropped frames
//   o_Busy             : high while a frame is in progress
// Handshake: i_RX_DV is a valid-only strobe with no ready; every strobe is
// consumed on the edge it is sampled, so the parser can never stall the
// receiver. o_Wr_DV is likewise a valid-only strobe to the register bank.
// -----------------------------------------------------------------------------
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CLKS = 8680
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_RX_DV,
  input  logic [7:0]  i_RX_Byte,
  output logic        o_Wr_DV,
  output logic [7:0]  o_Wr_Addr,
  output logic [15:0] o_Wr_Data,
  output logic [7:0]  o_Err_Cnt,
  output logic        o_Busy
);

  state_e      state_q, state_d;
  logic [7:0]  addr_sh_q, addr_sh_d;
  logic [15:0] data_sh_q, data_sh_d;
  logic        wr_dv_q, wr_dv_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        commit;
  logic        err_inc;
  logic        to_clr;
  logic        to_expire;

  // In any in-frame state every strobe is accepted, so a strobe always
  // restarts the idle window; idle clocks in a frame advance it.
  assign to_clr = (state_q == S_SYNC) || i_RX_DV;

  uart_cmd_timeout #(
    .LIMIT (TIMEOUT_CLKS)
  ) u_timeout (
    .clk      (i_Clock),
    .rst_n    (i_Rst_n),
    .i_clr    (to_clr),
    .i_en     (!to_clr),
    .o_expire (to_expire)
  );

  always_comb begin
    state_d   = state_q;
    addr_sh_d = addr_sh_q;
    data_sh_d = data_sh_q;
    wr_dv_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_cnt_d = err_cnt_q;
    commit    = 1'b0;
    err_inc   = 1'b0;

    case (state_q)
      S_SYNC: begin
        if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (i_RX_DV) begin
          addr_sh_d = i_RX_Byte;
          state_d   = S_DH;
        end
      end
      S_DH: begin
        if (i_RX_DV) begin
          data_sh_d[15:8] = i_RX_Byte;
          state_d         = S_DL;
        end
      end
      S_DL: begin
        if (i_RX_DV) begin
          data_sh_d[7:0] = i_RX_Byte;
`ifdef UART_CMD_CHKSUM_EN
          state_d        = S_CHK;
`else
          commit         = 1'b1;
          state_d        = S_SYNC;
`endif
        end
      end
`ifdef UART_CMD_CHKSUM_EN
      S_CHK: begin
        if (i_RX_DV) begin
          state_d = S_SYNC;
          if (i_RX_Byte == frame_chksum(addr_sh_q, data_sh_q)) begin
            commit = 1'b1;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_SYNC;
    endcase

    // Expiry only fires with no strobe present, so it never races a byte.
    if (to_expire) begin
      state_d = S_SYNC;
      err_inc = 1'b1;
    end

    // Shadow *_d values are used so the final data byte of a 4-byte frame
    // lands in the committed word on the same edge.
    if (commit) begin
      wr_dv_d   = 1'b1;
      wr_addr_d = addr_sh_d;
      wr_data_d = data_sh_d;
    end

    if (err_inc && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= S_SYNC;
      addr_sh_q <= '0;
      data_sh_q <= '0;
      wr_dv_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_sh_q <= addr_sh_d;
      data_sh_q <= data_sh_d;
      wr_dv_q   <= wr_dv_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_Wr_DV   = wr_dv_q;
  assign o_Wr_Addr = wr_addr_q;
  assign o_Wr_Data = wr_data_q;
  assign o_Err_Cnt = err_cnt_q;
  assign o_Busy    = (state_q != S_SYNC);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parser
// Self-checking bench for uart_cmd_parser. A frame-level reference model
// (byte queue + inter-byte gap rule) predicts commits and the error count.
// Works with and without UART_CMD_CHKSUM_EN.
// -----------------------------------------------------------------------------
module tb_uart_cmd_parser;
  import uart_cmd_pkg::*;

`ifdef UART_CMD_CHKSUM_EN
  localparam int TO   = 8680;
  localparam int FLEN = 5;
`else
  // Shorter window keeps the timeout-driven saturation run within budget.
  localparam int TO   = 150;
  localparam int FLEN = 4;
`endif
  localparam int W = 56;

  // ---------------- clock / reset ----------------
  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        rx_dv   = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        wr_dv;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  err_cnt;
  logic        busy;
  logic [31:0] cyc = 32'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  uart_cmd_parser #(
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .i_Clock   (clk),
    .i_Rst_n   (rst_n),
    .i_RX_DV   (rx_dv),
    .i_RX_Byte (rx_byte),
    .o_Wr_DV   (wr_dv),
    .o_Wr_Addr (wr_addr),
    .o_Wr_Data (wr_data),
    .o_Err_Cnt (err_cnt),
    .o_Busy    (busy)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_err    = 0;
  logic [W-1:0] exp_q[$];     // {strobe edge, addr, data}

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mq[$];
  logic [31:0] m_last = 32'd0;
  logic [7:0]  m_err  = 8'd0;
  logic [7:0]  m_addr = 8'd0;
  logic [15:0] m_data = 16'd0;

  task automatic m_count_err();
    if (m_err != 8'd255) m_err = m_err + 8'd1;
  endtask

  // A byte is kept if it arrives within TO edges of the previous frame byte;
  // a longer gap drops the partial frame and the byte is hunted afresh.
  task automatic model_byte(input logic [7:0] b, input logic [31:0] e);
    logic [7:0] s;
    if (mq.size() != 0 && (e - m_last) > 32'(TO)) begin
      m_count_err();
      mq.delete();
    end
    if (mq.size() == 0) begin
      if (b == 8'hA5) mq.push_back(b);
    end else begin
      mq.push_back(b);
    end
    if (mq.size() == FLEN) begin
      s = mq[1] + mq[2] + mq[3];
      if (FLEN == 4 || mq[FLEN-1] == s) begin
        m_addr = mq[1];
        m_data = {mq[2], mq[3]};
        exp_q.push_back({e, m_addr, m_data});
      end else begin
        m_count_err();
      end
      mq.delete();
    end
    m_last = e;
  endtask

  task automatic model_flush();
    if (mq.size() != 0 && (cyc - m_last) >= 32'(TO)) begin
      m_count_err();
      mq.delete();
    end
  endtask

  // ---------------- drivers ----------------
  int nb = 0;

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap - 1) @(posedge clk);
    #1;
    rx_dv   = 1'b1;
    rx_byte = b;
    model_byte(b, cyc + 32'd1);
    @(posedge clk);
    #1;
    rx_dv   = 1'b0;
    rx_byte = 8'($urandom_range(0, 255));
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] dh,
                            input logic [7:0] dl, input logic [7:0] c,
                            input int gap);
    send_byte(8'hA5, gap);
    send_byte(a, gap);
    send_byte(dh, gap);
    send_byte(dl, gap);
    if (FLEN == 5) send_byte(c, gap);
  endtask

  function automatic int pick_gap();
    nb++;
    if (nb % 60 == 30) return ((nb / 60) % 2 == 0) ? TO : TO + 1;
    return $urandom_range(1, 4);
  endfunction

  task automatic settle_check(input string tag);
    repeat (3) @(posedge clk);
    #1;
    model_flush();
    check({tag, "_err"},  W'(err_cnt), W'(m_err));
    check({tag, "_addr"}, W'(wr_addr), W'(m_addr));
    check({tag, "_data"}, W'(wr_data), W'(m_data));
  endtask

  // ---------------- commit monitor ----------------
  always @(negedge clk) begin
    if (rst_n && wr_dv) begin
      check("busy_at_commit", W'(busy), W'(0));
      if (exp_q.size() == 0) check("wr_spurious", W'(1), W'(0));
      else check("wr_strobe", {cyc, wr_addr, wr_data}, exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] a, dh, dl, c;
    int kind;

    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_dv",   W'(wr_dv),   W'(0));
    check("rst_wr_addr", W'(wr_addr), W'(0));
    check("rst_wr_data", W'(wr_data), W'(0));
    check("rst_err",     W'(err_cnt), W'(0));
    check("rst_busy",    W'(busy),    W'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Good frame, one byte per 100 clocks.
    send_frame(ADDR_KP, 8'h12, 8'h34, 8'h47, 100);
    settle_check("good");

    // Bad checksum, then a good frame.
    send_frame(ADDR_KI, 8'h00, 8'h10, 8'h00, 2);
    settle_check("badchk");
    send_frame(ADDR_KD, 8'h00, 8'h05, 8'h08, 2);
    settle_check("after_bad");

    // Garbage hunt (SYNC value with DV low is also driven between bytes).
    send_byte(8'h00, 3);
    send_byte(8'hFF, 1);
    send_byte(8'h5A, 2);
    send_frame(ADDR_SETPOINT, 8'h03, 8'hE8, 8'hEF, 1);
    settle_check("hunt");

    // Timeout: busy must drop exactly TO edges after the 2nd strobe.
    send_byte(8'hA5, 5);
    send_byte(ADDR_KP, 1);
    repeat (TO - 1) @(posedge clk);
    #1;
    check("to_busy_before", W'(busy), W'(1));
    @(posedge clk);
    #1;
    check("to_busy_after", W'(busy), W'(0));
    settle_check("timeout");

    // Strobe landing on the expiry cycle wins.
    send_byte(8'hA5, 3);
    send_byte(ADDR_KP, 1);
    send_byte(8'h12, TO);
    send_byte(8'h34, 1);
    if (FLEN == 5) send_byte(8'h47, 1);
    settle_check("to_edge");

    // Randomized frames, garbage and occasional boundary gaps.
    for (int i = 0; i < 50; i++) begin
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        send_byte(8'($urandom_range(0, 255)), pick_gap());
      end else begin
        a  = 8'($urandom_range(0, 255));
        dh = 8'($urandom_range(0, 255));
        dl = 8'($urandom_range(0, 255));
        c  = a + dh + dl;
        if (kind >= 8) c = c + 8'($urandom_range(1, 255));
        send_byte(8'hA5, pick_gap());
        send_byte(a, pick_gap());
        send_byte(dh, pick_gap());
        send_byte(dl, pick_gap());
        if (FLEN == 5) send_byte(c, pick_gap());
      end
    end
    settle_check("random");

    // Reset mid-frame: outputs clear at once, partial frame discarded.
    send_frame(ADDR_KP, 8'hBE, 8'hEF, 8'hAC, 1);
    send_byte(8'hA5, 2);
    send_byte(ADDR_KP, 2);
    send_byte(8'h12, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wr_dv",   W'(wr_dv),   W'(0));
    check("arst_wr_addr", W'(wr_addr), W'(0));
    check("arst_wr_data", W'(wr_data), W'(0));
    check("arst_err",     W'(err_cnt), W'(0));
    check("arst_busy",    W'(busy),    W'(0));
    mq.delete();
    m_err  = 8'd0;
    m_addr = 8'd0;
    m_data = 16'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(ADDR_KI, 8'h12, 8'h34, 8'h48, 2);
    settle_check("post_rst");

    // Error-count saturation.
    for (int i = 0; i < 300; i++) begin
      if (FLEN == 5) send_frame(ADDR_KI, 8'h00, 8'h10, 8'h00, 1);
      else send_byte(8'hA5, TO + 2);
    end

    repeat (TO + 3) @(posedge clk);
    #1;
    model_flush();
    check("sat_err_const", W'(err_cnt), W'(255));
    check("final_err",     W'(err_cnt), W'(m_err));
    check("final_addr",    W'(wr_addr), W'(m_addr));
    check("final_data",    W'(wr_data), W'(m_data));
    check("final_busy",    W'(busy),    W'(0));
    check("final_pending", W'(exp_q.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
